// File: rtl/picomips_pkg.sv
// Shared types and key assignments for the picoMIPS board I/O controller.
package picomips_pkg;

  typedef enum logic [1:0] {S_RESET, S_RUN, S_STEP} io_state_t;

  localparam int KEY_RST  = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_MODE = 2;

  function automatic io_state_t mode_state(input logic run);
    return run ? S_RUN : S_STEP;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One key: two-flop synchroniser, stable-count debouncer and a press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_s;

  assign w_s = ~r_sync2;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      // NOTE: sync flops reset to the released (high) level so a reset never looks like a press.
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, giving a true shift chain.
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btn_level = r_level;
  assign btn_press = r_press;

endmodule

// File: rtl/picomips_io_ctrl.sv
// Board I/O controller: debounced keys, stretched core reset, RUN/STEP clock enable, LED register.
module picomips_io_ctrl
  import picomips_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RST_HOLD        = 8,
  parameter int LED_W           = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [LED_W-1:0] led_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             core_nRst,
  output logic             core_en,
  output logic             run_mode,
  output logic [LED_W-1:0] LED
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;

  io_state_t        r_state;
  logic [HW-1:0]    r_hold;
  logic             r_core_nrst;
  logic             r_core_en;
  logic             r_run_mode;
  logic [LED_W-1:0] r_led;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_key
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .nRst      (nRst),
      .btn_raw   (btn_raw[gi]),
      .btn_level (w_level[gi]),
      .btn_press (w_press[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state     <= S_RESET;
      r_hold      <= '0;
      r_core_nrst <= 1'b0;
      r_core_en   <= 1'b0;
      r_run_mode  <= 1'b1;
      r_led       <= '0;
    end else begin
      // The LED follows whatever the core produced during its last enabled cycle.
      if (r_state == S_RESET) begin
        r_led <= '0;
      end else if (r_core_en) begin
        r_led <= led_in;
      end

      if (w_level[KEY_RST]) begin
        r_state     <= S_RESET;
        r_hold      <= '0;
        r_core_nrst <= 1'b0;
        r_core_en   <= 1'b0;
      end else begin
        case (r_state)
          S_RESET: begin
            if (r_hold == HW'(RST_HOLD - 1)) begin
              r_state     <= mode_state(r_run_mode);
              r_hold      <= '0;
              r_core_nrst <= 1'b1;
              r_core_en   <= r_run_mode;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          S_RUN: begin
            if (w_press[KEY_MODE]) begin
              r_state    <= S_STEP;
              r_run_mode <= 1'b0;
              r_core_en  <= 1'b0;
            end else begin
              r_core_en <= 1'b1;
            end
          end
          S_STEP: begin
            // A mode toggle swallows a step request arriving in the same cycle.
            if (w_press[KEY_MODE]) begin
              r_state    <= S_RUN;
              r_run_mode <= 1'b1;
              r_core_en  <= 1'b1;
            end else begin
              r_core_en <= w_press[KEY_STEP];
            end
          end
          default: begin
            r_state     <= S_RESET;
            r_hold      <= '0;
            r_core_nrst <= 1'b0;
            r_core_en   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign btn_level = w_level;
  assign btn_press = w_press;
  assign core_nRst = r_core_nrst;
  assign core_en   = r_core_en;
  assign run_mode  = r_run_mode;
  assign LED       = r_led;

endmodule

// File: tb/tb_picomips_io_ctrl.sv
// Self-checking bench for picomips_io_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_picomips_io_ctrl;

  localparam int N_BTN = 4;
  localparam int DB    = 4;
  localparam int RH    = 3;
  localparam int LW    = 8;

  logic             clk = 1'b0;
  logic             nRst;
  logic [N_BTN-1:0] btn_raw;
  logic [LW-1:0]    led_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic             core_nRst;
  logic             core_en;
  logic             run_mode;
  logic [LW-1:0]    LED;

  always #5 clk = ~clk;

  picomips_io_ctrl #(
    .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DB), .RST_HOLD(RH), .LED_W(LW)
  ) dut (
    .clk(clk), .nRst(nRst), .btn_raw(btn_raw), .led_in(led_in),
    .btn_level(btn_level), .btn_press(btn_press), .core_nRst(core_nRst),
    .core_en(core_en), .run_mode(run_mode), .LED(LED)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: keys become stable after DB consecutive differing samples.
  logic [N_BTN-1:0] m_q1, m_q2, m_level, m_level_d, m_press;
  logic [DB-1:0]    m_win [N_BTN];
  int               m_fill [N_BTN];
  logic             m_in_reset, m_nrst, m_en, m_mode;
  int               m_rel;
  logic [LW-1:0]    m_led;

  task automatic model_edge();
    logic [N_BTN-1:0] s;
    if (!nRst) begin
      m_q1 = '1; m_q2 = '1; m_level = '0; m_level_d = '0; m_press = '0;
      for (int i = 0; i < N_BTN; i++) begin m_win[i] = '0; m_fill[i] = 0; end
      m_in_reset = 1'b1; m_rel = 0; m_nrst = 1'b0; m_en = 1'b0; m_mode = 1'b1; m_led = '0;
    end else begin
      s = ~m_q2;
      if (m_in_reset) m_led = '0;
      else if (m_en) m_led = led_in;
      if (m_level[0]) begin
        m_in_reset = 1'b1; m_rel = 0; m_nrst = 1'b0; m_en = 1'b0;
      end else if (m_in_reset) begin
        m_rel++;
        if (m_rel == RH) begin
          m_in_reset = 1'b0; m_rel = 0; m_nrst = 1'b1; m_en = m_mode;
        end
      end else if (m_press[2]) begin
        m_mode = ~m_mode;
        m_en   = m_mode;
      end else begin
        m_en = m_mode | m_press[1];
      end
      m_press   = m_level & ~m_level_d;
      m_level_d = m_level;
      for (int i = 0; i < N_BTN; i++) begin
        m_win[i] = {m_win[i][DB-2:0], s[i]};
        if (m_fill[i] < DB) m_fill[i]++;
        if (m_fill[i] == DB &&
            ((m_level[i] && m_win[i] == '0) || (!m_level[i] && m_win[i] == '1)))
          m_level[i] = ~m_level[i];
      end
      m_q2 = m_q1;
      m_q1 = btn_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    nRst = 1'b0; btn_raw = '1; led_in = 8'h00;
    tick(); tick();
    n_checks++;
    if ({btn_level, btn_press, core_nRst, core_en, run_mode, LED} !== {4'h0, 4'h0, 3'b001, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h",
               {btn_level, btn_press, core_nRst, core_en, run_mode, LED}, {4'h0, 4'h0, 3'b001, 8'h00});
    end
    nRst = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      logic exp_r;
      led_in = 8'($urandom);
      tick();
      exp_r = (c >= RH);
      n_checks++;
      if (core_nRst !== exp_r) begin
        n_fail++; $display("FAIL reset_release c=%0d: got %b expected %b", c, core_nRst, exp_r);
      end
    end
    n_checks++;
    if ({core_en, run_mode} !== 2'b11) begin
      n_fail++; $display("FAIL reset_run: got en/mode %b expected 11", {core_en, run_mode});
    end
  endtask

  task automatic test_glitch_latency();
    btn_raw[1] = 1'b0; tick(); btn_raw[1] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_checks++;
      if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0) begin
        n_fail++; $display("FAIL glitch n=%0d: got level/press %b%b expected 00", n, btn_level[1], btn_press[1]);
      end
    end
    btn_raw[1] = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      logic exp_l, exp_p;
      tick();
      exp_l = (n >= 6); exp_p = (n == 7);
      n_checks++;
      if (btn_level[1] !== exp_l || btn_press[1] !== exp_p) begin
        n_fail++;
        $display("FAIL press_latency n=%0d: got level/press %b%b expected %b%b",
                 n, btn_level[1], btn_press[1], exp_l, exp_p);
      end
    end
    btn_raw[1] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      logic exp_l;
      tick();
      exp_l = (n < 6);
      n_checks++;
      if (btn_level[1] !== exp_l || btn_press[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL release n=%0d: got level/press %b%b expected %b0", n, btn_level[1], btn_press[1], exp_l);
      end
    end
  endtask

  task automatic test_step_mode();
    int hi;
    led_in = 8'h3C;
    btn_raw[2] = 1'b0; repeat (10) tick();
    btn_raw[2] = 1'b1; repeat (8) tick();
    n_checks++;
    if ({run_mode, core_en, LED} !== {2'b00, 8'h3C}) begin
      n_fail++; $display("FAIL step_enter: got mode/en/LED %h expected %h", {run_mode, core_en, LED}, {2'b00, 8'h3C});
    end
    led_in = 8'hA5; repeat (3) tick();
    n_checks++;
    if (LED !== 8'h3C) begin
      n_fail++; $display("FAIL step_led_hold: got %h expected 3c", LED);
    end
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      btn_raw[1] = 1'b0;
      for (int n = 1; n <= 12; n++) begin tick(); if (core_en) hi++; end
      btn_raw[1] = 1'b1;
      for (int n = 1; n <= 10; n++) begin tick(); if (core_en) hi++; end
      n_checks++;
      if (hi !== 1) begin
        n_fail++; $display("FAIL step_pulse p=%0d: got %0d enable cycles expected 1", p, hi);
      end
      n_checks++;
      if (LED !== 8'hA5) begin
        n_fail++; $display("FAIL step_led p=%0d: got %h expected a5", p, LED);
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_raw[1] = 1'b0; btn_raw[2] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      logic exp_v;
      led_in = 8'($urandom);
      tick();
      exp_v = (n >= 8);
      n_checks++;
      if (core_en !== exp_v || run_mode !== exp_v) begin
        n_fail++;
        $display("FAIL simultaneous n=%0d: got en/mode %b%b expected %b%b", n, core_en, run_mode, exp_v, exp_v);
      end
    end
    btn_raw[1] = 1'b1; btn_raw[2] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      n_checks++;
      if ({core_en, run_mode} !== 2'b11) begin
        n_fail++; $display("FAIL simultaneous_release n=%0d: got en/mode %b expected 11", n, {core_en, run_mode});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] got, exp;
    btn_raw[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      logic exp_r;
      led_in = 8'($urandom);
      tick();
      exp_r = (n < 7);
      n_checks++;
      if (core_nRst !== exp_r) begin
        n_fail++; $display("FAIL mid_reset n=%0d: got core_nRst %b expected %b", n, core_nRst, exp_r);
      end
    end
    n_checks++;
    if (LED !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_led: got %h expected 00", LED);
    end
    btn_raw[0] = 1'b1; repeat (4) tick();
    btn_raw[0] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      led_in = 8'($urandom);
      tick();
      got = {btn_level, btn_press, core_nRst, core_en, run_mode, LED};
      exp = {m_level, m_press, m_nrst, m_en, m_mode, m_led};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL repress_model n=%0d: got %h expected %h", n, got, exp);
      end
    end
    btn_raw[0] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      logic exp_r;
      tick();
      exp_r = (n >= 9);
      n_checks++;
      if (core_nRst !== exp_r) begin
        n_fail++; $display("FAIL hold_release n=%0d: got core_nRst %b expected %b", n, core_nRst, exp_r);
      end
    end
    n_checks++;
    if ({run_mode, core_en} !== 2'b11) begin
      n_fail++; $display("FAIL mode_restore_run: got mode/en %b expected 11", {run_mode, core_en});
    end
  endtask

  task automatic test_block_reset();
    btn_raw[2] = 1'b0; repeat (10) tick();
    btn_raw[2] = 1'b1; repeat (8) tick();
    btn_raw[0] = 1'b0; repeat (10) tick();
    btn_raw[0] = 1'b1; repeat (12) tick();
    n_checks++;
    if ({core_nRst, run_mode, core_en} !== 3'b100) begin
      n_fail++; $display("FAIL mode_restore_step: got nRst/mode/en %b expected 100", {core_nRst, run_mode, core_en});
    end
    btn_raw[1] = 1'b0; repeat (8) tick();
    nRst = 1'b0; tick();
    n_checks++;
    if ({btn_level, btn_press, core_nRst, core_en, run_mode, LED} !== {4'h0, 4'h0, 3'b001, 8'h00}) begin
      n_fail++;
      $display("FAIL block_reset: got %h expected %h",
               {btn_level, btn_press, core_nRst, core_en, run_mode, LED}, {4'h0, 4'h0, 3'b001, 8'h00});
    end
    nRst = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      logic exp_l;
      tick();
      exp_l = (n >= 6);
      n_checks++;
      if (btn_level[1] !== exp_l) begin
        n_fail++; $display("FAIL redebounce n=%0d: got %b expected %b", n, btn_level[1], exp_l);
      end
    end
    btn_raw[1] = 1'b1; repeat (10) tick();
  endtask

  task automatic test_random();
    logic [18:0] got, exp;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N_BTN; i++)
        if ($urandom_range(0, (i == 0) ? 59 : 7) == 0) btn_raw[i] = ~btn_raw[i];
      nRst   = ($urandom_range(0, 249) != 0);
      led_in = 8'($urandom);
      tick();
      got = {btn_level, btn_press, core_nRst, core_en, run_mode, LED};
      exp = {m_level, m_press, m_nrst, m_en, m_mode, m_led};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random n=%0d: got %h expected %h", n, got, exp);
      end
    end
    nRst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch_latency();
    test_step_mode();
    test_simultaneous();
    test_reset_mid();
    test_block_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
